baud_clk_gen: RTL and testbench
===============================

Name: baud_clk_gen

Overview:
- Parametrised fractional-N baud/oversample clock generator; next generation of the team's fixed UART clock divider.
- Derives from `clk` a single-cycle oversample strobe, a single-cycle baud strobe (one per OSR oversample strobes) and a 50%-duty baud-rate clock.
- Divisor is runtime-programmable through a glitch-free shadow register.
- Feeds UART TX/RX and any other block in the car design that needs a programmable low-rate timebase.

Parameters:
- CNT_W, 16: width of integer divisor and period counter.
- FRAC_W, 4: width of fractional divisor and phase accumulator.
- OSR, 16: oversample ratio (os_tick events per tick); even, >= 2.
- DIV_DEFAULT, 1086: integer divisor loaded at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  run enable.
- div_int  in  CNT_W  integer divisor request.
- div_frac  in  FRAC_W  fractional divisor request (units of 2^-FRAC_W).
- div_load  in  1  one-cycle strobe: capture div_int/div_frac.
- os_tick  out  1  oversample strobe, one clk cycle wide.
- tick  out  1  baud strobe, one clk cycle wide.
- clk_out  out  1  50%-duty clock at tick rate.
- cfg_pending  out  1  a captured divisor is waiting to be applied.

Behaviour:
- **Reset (async assert, sync-release use):**
  - Active divisor = DIV_DEFAULT.0; pending = 0.
  - Period counter cnt = 0; phase accumulator acc = 0; oversample counter os_cnt = 0.
  - Outputs os_tick, tick, clk_out and cfg_pending all 0.
- **Event definition:** an "event" is a clk edge where en = 1 and cnt == period-1.
  - period = act_int + carry, where carry is the stored carry from the previous event (0 after reset or apply).
  - At an event: cnt <= 0; os_tick <= 1; {carry, acc} <= acc + act_frac.
  - At other edges with en = 1: cnt <= cnt + 1; os_tick <= 0.
  - All outputs are registered.
- **Timing:**
  - First os_tick is visible after exactly `period` enabled edges, counted from cnt = 0.
  - Average os_tick spacing is act_int + act_frac/2^FRAC_W.
  - With act_frac = 0, spacing is exactly act_int.
- **os_cnt:** increments modulo OSR on each event.
  - tick <= 1 on the event where os_cnt == OSR-1; 0 otherwise. tick is coincident with os_tick.
  - clk_out <= 1 on the event where os_cnt == OSR/2-1.
  - clk_out <= 0 on the event where os_cnt == OSR-1.
- **en = 0:**
  - cnt, acc, carry and os_cnt clear to 0; os_tick, tick and clk_out driven 0.
  - When en returns to 1, counting restarts from 0 (deterministic phase).
- **Divisor load:**
  - div_load captures the request into the shadow register and sets pending.
  - A request with div_int < 2 is clamped to 2.
  - Pending values are applied at the next event. Apply means: act <= shadow; acc and carry cleared; os_cnt unaffected.
  - The interval starting at that event uses the new divisor. No truncated or stretched pulse occurs.
  - If en = 0, apply happens on the edge after capture.
  - cfg_pending = pending; it clears on the apply edge.
- **Simultaneous events:**
  - div_load coincident with an event: the new value is applied at that same event (bypass); pending stays 0.
  - div_load while pending = 1: the newer value overwrites the shadow.
- **Width rules:**
  - cnt is CNT_W+1 bits so that period = 2^CNT_W-1+1 cannot overflow.
  - acc addition is FRAC_W+1 bits; the MSB is the carry.
- **Reset mid-operation:** every register returns immediately to its reset value; any pending load is discarded.

Decomposition:
- **Shared package baud_pkg:**
  - Default CNT_W, FRAC_W and OSR constants.
  - DIV_MIN = 2.
  - Clamp function for div_int.
- **Sub-module frac_period_ctr:** holds cnt, acc and carry.
  - Inputs: en, act_int, act_frac, clear.
  - Output: a registered event strobe.
- **Top level:** holds the shadow/pending logic, os_cnt, tick and clk_out.

Test Plan:
- Reset then en = 1 with defaults -> os_tick every 1086 cycles, tick every 17376 cycles, clk_out high 8688 cycles and low 8688 cycles.
- div_int = 10, div_frac = 8 loaded -> interval spacings 10,10,11,10,11,...; first 32 intervals total 335 cycles.
- div_load of div_int = 20 mid-interval under div_int = 10 -> cfg_pending = 1 until the next os_tick; the following interval is exactly 20; no os_tick is shorter than 10.
- div_int = 0 or 1 loaded -> clamps to 2: os_tick every 2 cycles, tick every 32 cycles.
- en dropped for 5 cycles mid-period, then raised -> outputs 0 while low; first os_tick exactly div_int cycles after re-enable; os_cnt restarts at 0.
- reset asserted asynchronously between clk edges while clk_out = 1 and a load is pending -> all outputs 0 immediately; divisor returns to 1086; cfg_pending = 0.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants and helpers for the fractional-N baud clock generator.
package baud_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned FRAC_W_DEF      = 4;
    localparam int unsigned OSR_DEF         = 16;
    localparam int unsigned DIV_DEFAULT_DEF = 1086;
    localparam int unsigned DIV_MIN         = 2;

    // Integer divisors below DIV_MIN cannot produce a single-cycle strobe.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
    endfunction

endpackage

// File: rtl/frac_period_ctr.sv
// Fractional-N period counter: emits one event per act_int(+carry) enabled cycles.
module frac_period_ctr
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CNT_W-1:0]  act_int,
    input  logic [FRAC_W-1:0] act_frac,
    input  logic              clear,
    output logic              evt,
    output logic              evt_c
);

    localparam int unsigned PW = CNT_W + 1;
    localparam int unsigned AW = FRAC_W + 1;

    logic [PW-1:0]     cnt;
    logic [PW-1:0]     period;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [AW-1:0]     sum;

    // One extra bit keeps act_int + carry from wrapping at the top divisor.
    assign period = PW'(act_int) + PW'(carry);
    assign evt_c  = en && (cnt == (period - PW'(1)));
    assign sum    = AW'(acc) + AW'(act_frac);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            evt   <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            evt   <= 1'b0;
        end else if (evt_c) begin
            cnt <= '0;
            evt <= 1'b1;
            if (clear) begin
                acc   <= '0;
                carry <= 1'b0;
            end else begin
                acc   <= sum[FRAC_W-1:0];
                carry <= sum[FRAC_W];
            end
        end else begin
            cnt <= cnt + PW'(1);
            evt <= 1'b0;
            if (clear) begin
                acc   <= '0;
                carry <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/baud_clk_gen.sv
// Programmable fractional-N oversample/baud strobe and 50%-duty baud clock generator.
module baud_clk_gen
    import baud_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned FRAC_W      = FRAC_W_DEF,
    parameter int unsigned OSR         = OSR_DEF,
    parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              os_tick,
    output logic              tick,
    output logic              clk_out,
    output logic              cfg_pending
);

    localparam int unsigned        OS_W    = $clog2(OSR);
    localparam logic [OS_W-1:0]    OS_LAST = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0]    OS_MID  = OS_W'(OSR / 2 - 1);

    logic [CNT_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [CNT_W-1:0]  shd_int;
    logic [FRAC_W-1:0] shd_frac;
    logic              pending;
    logic [OS_W-1:0]   os_cnt;
    logic              evt_c;

    logic [CNT_W-1:0]  load_int;
    logic              bypass;
    logic              apply;
    logic [CNT_W-1:0]  nxt_int;
    logic [FRAC_W-1:0] nxt_frac;

    // Apply only on an event boundary so no interval is cut short or stretched.
    always_comb begin
        load_int = CNT_W'(clamp_div(32'(div_int)));
        bypass   = div_load && evt_c;
        apply    = en ? (evt_c && (pending || div_load)) : (pending && !div_load);
        nxt_int  = bypass ? load_int : shd_int;
        nxt_frac = bypass ? div_frac : shd_frac;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_int  <= CNT_W'(DIV_DEFAULT);
            act_frac <= '0;
            shd_int  <= CNT_W'(DIV_DEFAULT);
            shd_frac <= '0;
            pending  <= 1'b0;
        end else if (apply) begin
            act_int  <= nxt_int;
            act_frac <= nxt_frac;
            pending  <= 1'b0;
        end else if (div_load) begin
            shd_int  <= load_int;
            shd_frac <= div_frac;
            pending  <= 1'b1;
        end
    end

    assign cfg_pending = pending;

    frac_period_ctr #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .act_int  (act_int),
        .act_frac (act_frac),
        .clear    (apply),
        .evt      (os_tick),
        .evt_c    (evt_c)
    );

    // Oversample phase: tick on the last slot, clk_out high over the upper half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            os_cnt  <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (!en) begin
            os_cnt  <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (evt_c) begin
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            tick   <= (os_cnt == OS_LAST);
            if (os_cnt == OS_MID) begin
                clk_out <= 1'b1;
            end else if (os_cnt == OS_LAST) begin
                clk_out <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_clk_gen.sv
// Self-checking bench for baud_clk_gen: vector table, corner sequences, random vs model.
module tb_baud_clk_gen;

    localparam int FRAC_W      = 4;
    localparam int OSR         = 16;
    localparam int DIV_DEFAULT = 1086;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        os_tick;
    logic        tick;
    logic        clk_out;
    logic        cfg_pending;

    baud_clk_gen dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .div_load    (div_load),
        .os_tick     (os_tick),
        .tick        (tick),
        .clk_out     (clk_out),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d_int;
        int d_frac;
        int n;
        int exp_total;
        int exp_ticks;
        int exp_min;
        int exp_max;
    } vec_t;

    vec_t vecs[6];

    int total = 0;
    int bad = 0;

    // Reference model state: intervals since last restart, closed-form event times.
    int m_int, m_frac, sh_int, sh_frac, m_pend, m_el, m_k, m_osn;
    int e_os, e_tick, e_clk;

    int first_os, first_tick, rise1, rise2, fall, e, e2, sum, mn, mx, nt;
    logic prev_clk;

    function automatic int clampf(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_int = DIV_DEFAULT; m_frac = 0; sh_int = DIV_DEFAULT; sh_frac = 0;
        m_pend = 0; m_el = 0; m_k = 0; m_osn = 0;
        e_os = 0; e_tick = 0; e_clk = 0;
    endtask

    task automatic model_edge();
        int ev;
        if (!en) begin
            m_el = 0; m_k = 0; m_osn = 0;
            e_os = 0; e_tick = 0; e_clk = 0;
            if (div_load) begin
                sh_int = clampf(int'(div_int)); sh_frac = int'(div_frac); m_pend = 1;
            end else if (m_pend != 0) begin
                m_int = sh_int; m_frac = sh_frac; m_pend = 0;
            end
        end else begin
            m_el++;
            ev = (m_el == (m_k + 1) * m_int + ((m_k * m_frac) >> FRAC_W)) ? 1 : 0;
            if (ev != 0) begin
                e_os = 1;
                e_tick = (m_osn == OSR - 1) ? 1 : 0;
                if (m_osn == OSR / 2 - 1) e_clk = 1;
                else if (m_osn == OSR - 1) e_clk = 0;
                m_osn = (m_osn + 1) % OSR;
                m_k++;
                if (div_load) begin
                    m_int = clampf(int'(div_int)); m_frac = int'(div_frac);
                    m_pend = 0; m_el = 0; m_k = 0;
                end else if (m_pend != 0) begin
                    m_int = sh_int; m_frac = sh_frac;
                    m_pend = 0; m_el = 0; m_k = 0;
                end
            end else begin
                e_os = 0; e_tick = 0;
                if (div_load) begin
                    sh_int = clampf(int'(div_int)); sh_frac = int'(div_frac); m_pend = 1;
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("os_tick", int'(os_tick), e_os);
        check("tick", int'(tick), e_tick);
        check("clk_out", int'(clk_out), e_clk);
        check("cfg_pending", int'(cfg_pending), m_pend);
    endtask

    task automatic run_until_os(input int budget, output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!os_tick && edges < budget);
        if (!os_tick) begin
            total++;
            bad++;
            $display("FAIL os_tick_timeout: got none within %0d cycles", budget);
        end
    endtask

    task automatic load_idle(input int di, input int df);
        en = 1'b0;
        div_int = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{10, 8, 32, 335, 2, 10, 11};
        vecs[1] = '{0, 0, 32, 64, 2, 2, 2};
        vecs[2] = '{1, 0, 16, 32, 1, 2, 2};
        vecs[3] = '{7, 0, 10, 70, 0, 7, 7};
        vecs[4] = '{5, 4, 8, 41, 0, 5, 6};
        vecs[5] = '{3, 15, 16, 62, 1, 3, 4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_os_tick", int'(os_tick), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_cfg_pending", int'(cfg_pending), 0);
        #2;
        reset = 1'b1;
        en = 1'b1;
        model_reset();

        // Default divisor timing
        first_os = -1; first_tick = -1; rise1 = -1; rise2 = -1; fall = -1;
        prev_clk = 1'b0;
        for (int c = 1; c <= 27000; c++) begin
            step();
            if (os_tick && first_os < 0) first_os = c;
            if (tick && first_tick < 0) first_tick = c;
            if (clk_out && !prev_clk) begin
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            if (!clk_out && prev_clk && fall < 0) fall = c;
            prev_clk = clk_out;
            if (rise2 >= 0) break;
        end
        check("dflt_first_os", first_os, 1086);
        check("dflt_first_tick", first_tick, 17376);
        check("dflt_clk_high", fall - rise1, 8688);
        check("dflt_clk_low", rise2 - fall, 8688);

        // Vector table: spacing totals, extremes and baud ticks per divisor
        for (int v = 0; v < 6; v++) begin
            load_idle(vecs[v].d_int, vecs[v].d_frac);
            en = 1'b1;
            sum = 0; mn = 1 << 30; mx = 0; nt = 0;
            for (int i = 0; i < vecs[v].n; i++) begin
                run_until_os(100, e);
                sum += e;
                if (e < mn) mn = e;
                if (e > mx) mx = e;
                if (tick) nt++;
            end
            check("vec_total", sum, vecs[v].exp_total);
            check("vec_ticks", nt, vecs[v].exp_ticks);
            check("vec_min", mn, vecs[v].exp_min);
            check("vec_max", mx, vecs[v].exp_max);
        end

        // Mid-interval load waits for the boundary
        load_idle(10, 0);
        en = 1'b1;
        run_until_os(100, e);
        check("mid_first", e, 10);
        repeat (4) step();
        div_int = 16'd20;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("mid_pending_set", int'(cfg_pending), 1);
        run_until_os(100, e2);
        check("mid_old_interval", 5 + e2, 10);
        check("mid_pending_clr", int'(cfg_pending), 0);
        run_until_os(100, e);
        check("mid_new_interval", e, 20);

        // Enable drop restarts phase
        repeat (7) step();
        en = 1'b0;
        repeat (5) step();
        check("dis_outputs", int'({os_tick, tick, clk_out}), 0);
        en = 1'b1;
        run_until_os(100, e);
        check("reen_first_os", e, 20);
        e2 = e;
        while (!clk_out && e2 < 400) begin
            step();
            e2++;
        end
        check("reen_clk_rise", e2, 160);

        // Random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            en = ($urandom_range(0, 99) < 95);
            div_load = ($urandom_range(0, 99) < 3);
            div_int = 16'($urandom_range(0, 9));
            div_frac = 4'($urandom_range(0, 15));
            step();
        end
        div_load = 1'b0;

        // Asynchronous reset with clk_out high and a load pending
        load_idle(20, 0);
        en = 1'b1;
        e = 0;
        while (!clk_out && e < 400) begin
            step();
            e++;
        end
        check("ar_clk_high", int'(clk_out), 1);
        repeat (3) step();
        div_int = 16'd30;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("ar_pending", int'(cfg_pending), 1);
        #3;
        reset = 1'b0;
        #1;
        check("ar_os_tick", int'(os_tick), 0);
        check("ar_tick", int'(tick), 0);
        check("ar_clk_out", int'(clk_out), 0);
        check("ar_cfg_pending", int'(cfg_pending), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        run_until_os(1200, e);
        check("ar_default_div", e, 1086);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
